serial_nibble_adder: RTL



---
 rtl/serial_nibble_adder_pkg.sv | 18 +
 rtl/serial_nibble_adder_rca.sv | 24 ++
 rtl/serial_nibble_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble adder.
package serial_nibble_adder_pkg;

    // Width of one adder slice; the datapath streams this many bits per cycle.
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/serial_nibble_adder_rca.sv
// 4-bit ripple-carry adder slice used as the nibble datapath.
module RCA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, carry rippling upward.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single 4-bit
// ripple-carry slice, LSB nibble first, carry held in a register between nibbles.
module serial_nibble_adder
    import serial_nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [IDX_W+1:0]    bit_base;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                accept;
    logic                last_nibble;

    // Bit offset of the current nibble (idx * 4, as a shift).
    assign bit_base    = {idx_reg, 2'b00};
    assign nib_a       = a_reg[bit_base +: NIBBLE_W];
    assign nib_b       = b_reg[bit_base +: NIBBLE_W];
    assign accept      = in_valid & in_ready;
    assign last_nibble = (idx_reg == LAST_IDX);

    RCA_4bit u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept -> RUN for NIBBLES cycles -> DONE until consumed.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept)      state_next = RUN;
            RUN:     if (last_nibble) state_next = DONE;
            DONE:    if (out_ready)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is held low during reset.
    always_comb begin
        in_ready  = (state_reg == IDLE) & ~rst;
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DONE);
    end

    // Datapath: capture operands, then write one sum nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[bit_base +: NIBBLE_W] <= nib_sum;
                    carry_reg                     <= nib_cout;
                    if (last_nibble) begin
                        // Index parks at 0 so it never points past the operands.
                        idx_reg  <= '0;
                        cout_reg <= nib_cout;
                        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (nib_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    // DONE: results held until the consumer takes them.
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
